// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage and the alu_flags unit it feeds:
// widths, opcodes, flag bit positions and the issue FSM encoding.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_RES_W  = 2 * ALU_DATA_W;
    localparam int ALU_FLAG_W = 4;

    localparam logic [3:0] OP_NOT   = 4'b0000;
    localparam logic [3:0] OP_NAND  = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_RIGHT = 4'b1000;
    localparam logic [3:0] OP_ARTH  = 4'b1001;
    localparam logic [3:0] OP_ILL0  = 4'b1010;
    localparam logic [3:0] OP_ILL1  = 4'b1011;
    localparam logic [3:0] OP_XNOR  = 4'b1100;
    localparam logic [3:0] OP_INC   = 4'b1101;
    localparam logic [3:0] OP_DEC   = 4'b1110;
    localparam logic [3:0] OP_LEFT  = 4'b1111;

    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } issue_state_e;

    // The two opcodes in the 101x hole have no ALU function behind them.
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ILL0: legal = 1'b0;
            OP_ILL1: legal = 1'b0;
            default: legal = 1'b1;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the combinational alu_flags unit: accepts a command,
// enables the ALU for one cycle, captures its result and hands back a response.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int RES_W  = 2 * DATA_W,
    parameter int FLAG_W = ALU_FLAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_fwd,
    output logic [DATA_W-1:0] alu_opa,
    output logic [DATA_W-1:0] alu_opb,
    output logic [3:0]        alu_opcode,
    output logic              alu_enable,
    input  logic [RES_W-1:0]  alu_result,
    input  logic [FLAG_W-1:0] alu_status,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic [FLAG_W-1:0] rsp_status,
    output logic              rsp_err,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              flags_clr
);

    issue_state_e      state_q, state_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0] rsp_status_q, rsp_status_d;
    logic              rsp_err_q, rsp_err_d;
    logic [FLAG_W-1:0] sticky_q, sticky_d;
    logic [DATA_W-1:0] last_result_q, last_result_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              alu_enable_q, alu_enable_d;
    logic              rsp_valid_q, rsp_valid_d;

    // Next-state, operand latching, result capture and sticky flag update.
    always_comb begin
        state_d       = state_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        opcode_d      = opcode_q;
        rsp_result_d  = rsp_result_q;
        rsp_status_d  = rsp_status_q;
        rsp_err_d     = rsp_err_q;
        last_result_d = last_result_q;

        if (flags_clr) begin
            sticky_d = {FLAG_W{1'b0}};
        end else begin
            sticky_d = sticky_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    opcode_d = cmd_opcode;
                    opa_d    = cmd_fwd ? last_result_q : cmd_a;
                    opb_d    = cmd_b;
                    if (is_legal_op(cmd_opcode)) begin
                        rsp_err_d = 1'b0;
                        state_d   = ST_EXEC;
                    end else begin
                        // Rejected command goes straight to the response with zeroed payload.
                        rsp_err_d    = 1'b1;
                        rsp_result_d = {RES_W{1'b0}};
                        rsp_status_d = {FLAG_W{1'b0}};
                        state_d      = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_result_d  = alu_result;
                rsp_status_d  = alu_status;
                last_result_d = alu_result[DATA_W-1:0];
                // A clear coinciding with a capture keeps the fresh status.
                if (flags_clr) begin
                    sticky_d = alu_status;
                end else begin
                    sticky_d = sticky_q | alu_status;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d  = (state_d == ST_IDLE);
        alu_enable_d = (state_d == ST_EXEC);
        rsp_valid_d  = (state_d == ST_RESP);
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            opa_q         <= {DATA_W{1'b0}};
            opb_q         <= {DATA_W{1'b0}};
            opcode_q      <= 4'b0000;
            rsp_result_q  <= {RES_W{1'b0}};
            rsp_status_q  <= {FLAG_W{1'b0}};
            rsp_err_q     <= 1'b0;
            sticky_q      <= {FLAG_W{1'b0}};
            last_result_q <= {DATA_W{1'b0}};
            cmd_ready_q   <= 1'b1;
            alu_enable_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            opcode_q      <= opcode_d;
            rsp_result_q  <= rsp_result_d;
            rsp_status_q  <= rsp_status_d;
            rsp_err_q     <= rsp_err_d;
            sticky_q      <= sticky_d;
            last_result_q <= last_result_d;
            cmd_ready_q   <= cmd_ready_d;
            alu_enable_q  <= alu_enable_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign alu_opa      = opa_q;
    assign alu_opb      = opb_q;
    assign alu_opcode   = opcode_q;
    assign alu_enable   = alu_enable_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_status   = rsp_status_q;
    assign rsp_err      = rsp_err_q;
    assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a small behavioural stand-in for
// the alu_flags unit; expected responses are hand-computed constants.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DW = 8;
    localparam int RW = 16;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_opcode = 4'b0000;
    logic [DW-1:0] cmd_a = 8'h00;
    logic [DW-1:0] cmd_b = 8'h00;
    logic          cmd_fwd = 1'b0;
    logic [DW-1:0] alu_opa, alu_opb;
    logic [3:0]    alu_opcode;
    logic          alu_enable;
    logic [RW-1:0] alu_result;
    logic [FW-1:0] alu_status;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [RW-1:0] rsp_result;
    logic [FW-1:0] rsp_status;
    logic          rsp_err;
    logic [FW-1:0] sticky_flags;
    logic          flags_clr = 1'b0;

    typedef struct packed {
        logic [RW-1:0] res;
        logic [FW-1:0] st;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   rsp_cnt = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fwd(cmd_fwd),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_opcode(alu_opcode), .alu_enable(alu_enable),
        .alu_result(alu_result), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_status(rsp_status), .rsp_err(rsp_err),
        .sticky_flags(sticky_flags), .flags_clr(flags_clr)
    );

    // Stand-in ALU: status is {C, V, Z, N}, Z over the full result, N = result[7].
    always_comb begin
        logic [8:0]    t;
        logic [RW-1:0] r;
        logic          c, v;
        t = 9'h000;
        c = 1'b0;
        v = 1'b0;
        case (alu_opcode)
            OP_ADD: begin
                t = {1'b0, alu_opa} + {1'b0, alu_opb};
                c = t[8];
                v = (alu_opa[7] == alu_opb[7]) && (t[7] != alu_opa[7]);
                r = {7'b0000000, t};
            end
            OP_SUB: begin
                t = {1'b0, alu_opa} - {1'b0, alu_opb};
                c = t[8];
                v = (alu_opa[7] != alu_opb[7]) && (t[7] != alu_opa[7]);
                r = {8'h00, t[7:0]};
            end
            OP_AND:  r = {8'h00, alu_opa & alu_opb};
            OP_OR:   r = {8'h00, alu_opa | alu_opb};
            OP_XOR:  r = {8'h00, alu_opa ^ alu_opb};
            default: r = {8'h00, ~alu_opa};
        endcase
        if (alu_enable) begin
            alu_result = r;
            alu_status = {c, v, (r == 16'h0000), r[7]};
        end else begin
            alu_result = 16'h0000;
            alu_status = 4'b0000;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is checked against the head of the queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=res:%0h/st:%0h/err:%0b expected=none",
                         rsp_result, rsp_status, rsp_err);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_status", rsp_status, e.st);
                chk("rsp_err", rsp_err, e.err);
            end
            rsp_cnt++;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic fwd, input logic [15:0] er, input logic [3:0] es,
                         input logic ee);
        exp_t e;
        int   n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_before_issue", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_fwd    = fwd;
        e.res = er;
        e.st  = es;
        e.err = ee;
        exp_q.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_fwd   = 1'b0;
        chk("accept_cmd_ready_low", cmd_ready, 0);
        if (ee) begin
            chk("err_rsp_valid_latency", rsp_valid, 1);
            chk("err_enable_low", alu_enable, 0);
        end else begin
            chk("exec_rsp_valid_low", rsp_valid, 0);
            chk("exec_enable_high", alu_enable, 1);
            chk("exec_alu_opcode", alu_opcode, op);
        end
    endtask

    task automatic wait_rsp(input logic no_en);
        int start;
        int n;
        start = rsp_cnt;
        n = 0;
        while (rsp_cnt == start && n < 30) begin
            @(negedge clk);
            if (no_en) chk("err_no_alu_enable", alu_enable, 0);
            n++;
        end
        if (rsp_cnt == start) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout actual=no_response expected=response");
        end
        @(posedge clk); #1;
    endtask

    initial begin : stim
        logic [RW-1:0] hold_res;
        logic [FW-1:0] hold_st;

        #12;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_sticky", sticky_flags, 0);
        chk("reset_alu_enable", alu_enable, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: SUB 50-50, response two edges after accept, Z set.
        issue(OP_SUB, 8'd50, 8'd50, 1'b0, 16'h0000, 4'b0010, 1'b0);
        @(posedge clk); #1;
        chk("sub_rsp_valid_latency", rsp_valid, 1);
        wait_rsp(1'b0);
        chk("sub_sticky", sticky_flags, 4'b0010);

        // 2: ADD 255+1 then forwarded ADD +5.
        issue(OP_ADD, 8'd255, 8'd1, 1'b0, 16'h0100, 4'b1000, 1'b0);
        wait_rsp(1'b0);
        issue(OP_ADD, 8'hAA, 8'd5, 1'b1, 16'h0005, 4'b0000, 1'b0);
        chk("fwd_alu_opa", alu_opa, 8'h00);
        chk("fwd_alu_opb", alu_opb, 8'h05);
        wait_rsp(1'b0);
        chk("add_sticky", sticky_flags, 4'b1010);

        // 3: illegal opcode.
        issue(4'b1010, 8'd7, 8'd9, 1'b0, 16'h0000, 4'b0000, 1'b1);
        wait_rsp(1'b1);
        chk("err_sticky_unchanged", sticky_flags, 4'b1010);

        // 4: back-pressure for 5 cycles with an ignored command pulse.
        rsp_ready = 1'b0;
        issue(OP_ADD, 8'd3, 8'd4, 1'b0, 16'h0007, 4'b0000, 1'b0);
        @(posedge clk); #1;
        hold_res = rsp_result;
        hold_st  = rsp_status;
        chk("bp_result_captured", hold_res, 16'h0007);
        for (int i = 0; i < 5; i++) begin
            cmd_valid  = (i == 2);
            cmd_opcode = OP_SUB;
            cmd_a      = 8'd9;
            cmd_b      = 8'd1;
            @(posedge clk); #1;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_result_stable", rsp_result, hold_res);
            chk("bp_status_stable", rsp_status, hold_st);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_rsp(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_extra_rsp", rsp_valid, 0);
        chk("bp_ignored_opa", alu_opa, 8'd3);
        chk("bp_queue_empty", exp_q.size(), 0);
        chk("bp_sticky", sticky_flags, 4'b1010);

        // 5: flags_clr during the EXEC cycle of ADD 127+1.
        issue(OP_ADD, 8'd127, 8'd1, 1'b0, 16'h0080, 4'b0101, 1'b0);
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        chk("clr_capture_wins", sticky_flags, 4'b0101);
        wait_rsp(1'b0);

        // 6: reset in the middle of EXEC.
        issue(OP_ADD, 8'd10, 8'd20, 1'b0, 16'h001E, 4'b0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_enable", alu_enable, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_sticky", sticky_flags, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rsp_after_release", rsp_valid, 0);
        end
        @(posedge clk); #1;
        issue(OP_ADD, 8'hFF, 8'd9, 1'b1, 16'h0009, 4'b0000, 1'b0);
        wait_rsp(1'b0);
        chk("post_rst_sticky", sticky_flags, 4'b0000);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
